button_conditioner: RTL and testbench

//  Front end for the four-button LFU light controller. Synchronises and debounces

---
 rtl/button_conditioner.sv | 160 ++++++++++++++++
 tb/tb_button_conditioner.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Button front end for the LFU controller: 2-FF sync, debounce, stuck masking, arbitration.
// Define BTN_RR_ARB_EN for round-robin arbitration; otherwise fixed priority b1 > b2 > b3 > b4.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STUCK_TICKS     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] raw_btn,
    input  logic       tick,
    output logic       b1,
    output logic       b2,
    output logic       b3,
    output logic       b4,
    output logic       valid,
    output logic [3:0] stuck
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW = $clog2(STUCK_TICKS + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] HOLD_LAST = SW'(STUCK_TICKS - 1);
    localparam logic [SW-1:0] HOLD_MAX  = SW'(STUCK_TICKS);

    logic [3:0]    sync_meta;
    logic [3:0]    synced;
    logic [3:0]    debounced;
    logic [3:0]    debounced_next;
    logic [DW-1:0] deb_cnt [4];
    logic [SW-1:0] hold_cnt [4];
    logic [3:0]    stuck_set;
    logic [3:0]    stuck_next;
    logic [3:0]    req;
    logic [3:0]    grant;
    logic [3:0]    grant_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= '0;
            synced    <= '0;
        end else begin
            sync_meta <= raw_btn;
            synced    <= sync_meta;
        end
    end

    // A new level is accepted on the edge where its disagreement run reaches DEBOUNCE_CYCLES.
    always_comb begin
        debounced_next = debounced;
        for (int i = 0; i < 4; i++) begin
            if ((synced[i] != debounced[i]) && (deb_cnt[i] == DEB_LAST)) begin
                debounced_next[i] = synced[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            debounced <= '0;
            for (int i = 0; i < 4; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            debounced <= debounced_next;
            for (int i = 0; i < 4; i++) begin
                if (synced[i] == debounced[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // The stuck flag takes effect on the tick that saturates the hold count, masking that same grant.
    always_comb begin
        stuck_set  = '0;
        stuck_next = '0;
        for (int i = 0; i < 4; i++) begin
            stuck_set[i]  = tick && debounced[i] && (hold_cnt[i] == HOLD_LAST);
            stuck_next[i] = (stuck[i] | stuck_set[i]) & debounced_next[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stuck <= '0;
            for (int i = 0; i < 4; i++) begin
                hold_cnt[i] <= '0;
            end
        end else begin
            stuck <= stuck_next;
            for (int i = 0; i < 4; i++) begin
                if (!debounced[i]) begin
                    hold_cnt[i] <= '0;
                end else if (tick && (hold_cnt[i] != HOLD_MAX)) begin
                    hold_cnt[i] <= hold_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign req = debounced & ~stuck_next;

`ifdef BTN_RR_ARB_EN
    logic [1:0] ptr;
    logic [1:0] grant_idx;
    logic [1:0] scan_idx;
    logic       found;

    always_comb begin
        grant     = '0;
        grant_idx = ptr;
        scan_idx  = ptr;
        found     = 1'b0;
        for (int k = 0; k < 4; k++) begin
            scan_idx = ptr + 2'(k);
            if (!found && req[scan_idx]) begin
                found           = 1'b1;
                grant[scan_idx] = 1'b1;
                grant_idx       = scan_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (tick && (req != 4'b0000)) begin
            ptr <= grant_idx + 2'd1;
        end
    end
`else
    // Isolating the lowest set bit gives b1 > b2 > b3 > b4.
    assign grant = req & (~req + 4'd1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q <= '0;
            valid   <= 1'b0;
        end else if (tick) begin
            grant_q <= grant;
            valid   <= (req != 4'b0000);
        end else begin
            valid   <= 1'b0;
        end
    end

    assign b1 = grant_q[0];
    assign b2 = grant_q[1];
    assign b3 = grant_q[2];
    assign b4 = grant_q[3];

    a_onehot_grant : assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
    a_valid_nonzero : assert property (@(posedge clk) disable iff (rst) valid |-> (grant_q != 4'b0000));

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus a randomized run
// compared cycle by cycle against a behavioural model of the debounce/stuck/arbitration rules.
module tb_button_conditioner;

    localparam int DB = 4;
    localparam int ST = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [3:0] raw_btn = 4'b0000;
    logic       b1, b2, b3, b4;
    logic       valid;
    logic [3:0] stuck;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [3:0] m_s1 = '0, m_s2 = '0, m_deb = '0, m_stuck = '0, m_b = '0;
    logic       m_valid = 1'b0;
    int         m_run[4];
    int         m_held[4];
    int         m_ptr = 0;

    button_conditioner #(.DEBOUNCE_CYCLES(DB), .STUCK_TICKS(ST)) dut (
        .clk(clk), .rst(rst), .raw_btn(raw_btn), .tick(tick),
        .b1(b1), .b2(b2), .b3(b3), .b4(b4), .valid(valid), .stuck(stuck)
    );

    always #5 clk = ~clk;

    // Model: a level is accepted after DB consecutive disagreeing edges; a button held
    // through ST ticks is stuck until it releases; grants come from debounced & ~stuck.
    task automatic model_step();
        logic [3:0] deb_new;
        logic [3:0] stuck_new;
        logic [3:0] req;
        logic [3:0] grant;
        int         held_new[4];
        int         idx;
        int         next_ptr;
        deb_new = '0;
        stuck_new = '0;
        req = '0;
        grant = '0;
        next_ptr = m_ptr;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0; m_stuck = '0; m_b = '0; m_valid = 1'b0; m_ptr = 0;
            for (int i = 0; i < 4; i++) begin m_run[i] = 0; m_held[i] = 0; end
            return;
        end
        for (int i = 0; i < 4; i++) begin
            deb_new[i] = m_deb[i];
            if (m_s2[i] != m_deb[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] >= DB) begin deb_new[i] = m_s2[i]; m_run[i] = 0; end
            end else begin
                m_run[i] = 0;
            end
            held_new[i]  = m_deb[i] ? m_held[i] + (tick ? 1 : 0) : 0;
            stuck_new[i] = deb_new[i] && m_deb[i] && (held_new[i] >= ST);
        end
        if (tick) begin
            req = m_deb & ~stuck_new;
            for (int k = 0; k < 4; k++) begin
`ifdef BTN_RR_ARB_EN
                idx = (m_ptr + k) % 4;
`else
                idx = k;
`endif
                if (grant == 4'b0000 && req[idx]) begin
                    grant[idx] = 1'b1;
                    next_ptr = (idx + 1) % 4;
                end
            end
            m_b = grant;
            m_valid = (req != 4'b0000);
            m_ptr = next_ptr;
        end else begin
            m_valid = 1'b0;
        end
        m_s2 = m_s1;
        m_s1 = raw_btn;
        m_deb = deb_new;
        m_stuck = stuck_new;
        for (int i = 0; i < 4; i++) m_held[i] = held_new[i];
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        tick = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1; tick = 1'b0; raw_btn = 4'b0000;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        raw_btn = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            tick = (k != 1);
            cycle();
            n_cmp++;
            if ({b4, b3, b2, b1} !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_b k=%0d: got %b want 0000", k, {b4, b3, b2, b1}); end
            n_cmp++;
            if (valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid k=%0d: got %b want 0", k, valid); end
            n_cmp++;
            if (stuck !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_stuck k=%0d: got %b want 0000", k, stuck); end
        end
        rst = 1'b0;
        tick = 1'b0;
        raw_btn = 4'b0000;
    endtask

    task automatic test_bounce();
        logic [3:0] exp_b;
        do_reset();
        idle(4);
        raw_btn = 4'b0001; idle(2);
        raw_btn = 4'b0000; idle(2);
        raw_btn = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            tick = (k == 2 || k == 4 || k == 6 || k == 7);
            cycle();
            exp_b = (k >= 7) ? 4'b0001 : 4'b0000;
            n_cmp++;
            if ({b4, b3, b2, b1} !== exp_b) begin n_fail++; $display("[TB] FAIL bounce_b edge=%0d: got %b want %b", k, {b4, b3, b2, b1}, exp_b); end
            n_cmp++;
            if (valid !== (k == 7)) begin n_fail++; $display("[TB] FAIL bounce_valid edge=%0d: got %b want %b", k, valid, (k == 7)); end
        end
        tick = 1'b0;
    endtask

    task automatic test_multi_press();
        logic [3:0] exp_second;
`ifdef BTN_RR_ARB_EN
        exp_second = 4'b0100;
`else
        exp_second = 4'b0010;
`endif
        do_reset();
        raw_btn = 4'b0110;
        idle(8);
        tick = 1'b1; cycle();
        n_cmp++;
        if ({b4, b3, b2, b1} !== 4'b0010 || valid !== 1'b1) begin n_fail++; $display("[TB] FAIL multi_tick1: got b=%b v=%b want b=0010 v=1", {b4, b3, b2, b1}, valid); end
        tick = 1'b0; cycle();
        n_cmp++;
        if ({b4, b3, b2, b1} !== 4'b0010 || valid !== 1'b0) begin n_fail++; $display("[TB] FAIL multi_hold: got b=%b v=%b want b=0010 v=0", {b4, b3, b2, b1}, valid); end
        tick = 1'b1; cycle();
        n_cmp++;
        if ({b4, b3, b2, b1} !== exp_second || valid !== 1'b1) begin n_fail++; $display("[TB] FAIL multi_tick2: got b=%b v=%b want b=%b v=1", {b4, b3, b2, b1}, valid, exp_second); end
        tick = 1'b0; cycle();
        tick = 1'b1; cycle();
        n_cmp++;
        if ({b4, b3, b2, b1} !== 4'b0000 || valid !== 1'b0 || stuck !== 4'b0110) begin n_fail++; $display("[TB] FAIL multi_tick3_stuck: got b=%b v=%b s=%b want b=0000 v=0 s=0110", {b4, b3, b2, b1}, valid, stuck); end
        tick = 1'b0;
        raw_btn = 4'b0000;
    endtask

    task automatic test_stuck();
        do_reset();
        raw_btn = 4'b1000;
        idle(8);
        for (int t = 1; t <= 3; t++) begin
            tick = 1'b1; cycle();
            n_cmp++;
            if (t < 3) begin
                if ({b4, b3, b2, b1} !== 4'b1000 || valid !== 1'b1 || stuck !== 4'b0000) begin n_fail++; $display("[TB] FAIL stuck_tick%0d: got b=%b v=%b s=%b want b=1000 v=1 s=0000", t, {b4, b3, b2, b1}, valid, stuck); end
            end else begin
                if ({b4, b3, b2, b1} !== 4'b0000 || valid !== 1'b0 || stuck !== 4'b1000) begin n_fail++; $display("[TB] FAIL stuck_tick3: got b=%b v=%b s=%b want b=0000 v=0 s=1000", {b4, b3, b2, b1}, valid, stuck); end
            end
            tick = 1'b0; cycle();
        end
        raw_btn = 4'b0000;
        idle(8);
        n_cmp++;
        if (stuck !== 4'b0000) begin n_fail++; $display("[TB] FAIL stuck_release: got %b want 0000", stuck); end
        raw_btn = 4'b1000;
        idle(8);
        tick = 1'b1; cycle();
        n_cmp++;
        if ({b4, b3, b2, b1} !== 4'b1000 || valid !== 1'b1) begin n_fail++; $display("[TB] FAIL stuck_repress: got b=%b v=%b want b=1000 v=1", {b4, b3, b2, b1}, valid); end
        tick = 1'b0;
        raw_btn = 4'b0000;
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        raw_btn = 4'b0001;
        idle(8);
        tick = 1'b1; cycle();
        n_cmp++;
        if ({b4, b3, b2, b1} !== 4'b0001 || valid !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_pre: got b=%b v=%b want b=0001 v=1", {b4, b3, b2, b1}, valid); end
        tick = 1'b0; rst = 1'b1; cycle();
        n_cmp++;
        if ({b4, b3, b2, b1} !== 4'b0000 || valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_drop: got b=%b v=%b want b=0000 v=0", {b4, b3, b2, b1}, valid); end
        rst = 1'b0; cycle();
        tick = 1'b1; cycle();
        n_cmp++;
        if ({b4, b3, b2, b1} !== 4'b0000 || valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_early_tick: got b=%b v=%b want b=0000 v=0", {b4, b3, b2, b1}, valid); end
        idle(8);
        tick = 1'b1; cycle();
        n_cmp++;
        if ({b4, b3, b2, b1} !== 4'b0001 || valid !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_regrant: got b=%b v=%b want b=0001 v=1", {b4, b3, b2, b1}, valid); end
        tick = 1'b0;
        raw_btn = 4'b0000;
    endtask

    task automatic test_collision();
        do_reset();
        idle(3);
        raw_btn = 4'b0010;
        idle(5);
        tick = 1'b1; cycle();
        n_cmp++;
        if ({b4, b3, b2, b1} !== 4'b0000 || valid !== 1'b0) begin n_fail++; $display("[TB] FAIL collide_same_edge: got b=%b v=%b want b=0000 v=0", {b4, b3, b2, b1}, valid); end
        tick = 1'b0; cycle();
        tick = 1'b1; cycle();
        n_cmp++;
        if ({b4, b3, b2, b1} !== 4'b0010 || valid !== 1'b1) begin n_fail++; $display("[TB] FAIL collide_next_tick: got b=%b v=%b want b=0010 v=1", {b4, b3, b2, b1}, valid); end
        tick = 1'b0;
        raw_btn = 4'b0000;
    endtask

    task automatic test_random();
        int rate;
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            rate = (n < 1000) ? 10 : 40;
            rst  = ($urandom_range(0, 299) == 0);
            tick = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, rate - 1) == 0) raw_btn[i] = ~raw_btn[i];
            end
            cycle();
            n_cmp++;
            if ({b4, b3, b2, b1} !== m_b) begin n_fail++; $display("[TB] FAIL rand_b n=%0d: got %b want %b", n, {b4, b3, b2, b1}, m_b); end
            n_cmp++;
            if (valid !== m_valid) begin n_fail++; $display("[TB] FAIL rand_valid n=%0d: got %b want %b", n, valid, m_valid); end
            n_cmp++;
            if (stuck !== m_stuck) begin n_fail++; $display("[TB] FAIL rand_stuck n=%0d: got %b want %b", n, stuck, m_stuck); end
        end
        rst = 1'b0;
        tick = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin m_run[i] = 0; m_held[i] = 0; end
        @(negedge clk);
        test_reset();
        test_bounce();
        test_multi_press();
        test_stuck();
        test_reset_mid_hold();
        test_collision();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
